internal_pps_gen: RTL and testbench
===================================

INTERNAL_PPS_GEN -- requirements
Module: internal_pps_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 156250000, meaning the nominal clock cycles per second.
REQ-002 SHALL have parameter PULSE_WIDTH, default 15625, meaning the pps_out high time in cycles; it SHALL be less than CLK_FREQ_HZ-MAX_ADJ.
REQ-003 SHALL have parameter MAX_ADJ, default 78125000, meaning the maximum adjustment magnitude in cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port areset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port pps_add, input, 33 bits: bit 32 is direction (1 = shorten, 0 = lengthen) and bits 31:0 are the magnitude in cycles.
REQ-007 SHALL have port pps_flag, input, 1 bit: every level change requests one adjustment using pps_add.
REQ-008 SHALL have port pps_pulse, output, 1 bit: single-cycle second marker.
REQ-009 SHALL have port pps_out, output, 1 bit: stretched PPS level.
REQ-010 SHALL have port sec_count, output, 32 bits: seconds elapsed.
REQ-011 SHALL have port adj_pending, output, 1 bit: an adjustment is captured but not yet applied.
REQ-012 SHALL have port adj_count, output, 16 bits: number of adjustments applied.
REQ-013 SHALL have port adj_overwrite, output, 1 bit: sticky flag, a pending adjustment was replaced.
REQ-014 SHALL have port adj_clamped, output, 1 bit: sticky flag, a magnitude exceeded MAX_ADJ.

Function
REQ-015 SHALL keep cycle counter cnt (32 bit) and active period per (32 bit); each cycle cnt increments, and when cnt==per-1, cnt SHALL wrap to 0 (the "wrap cycle").
REQ-016 SHALL assert pps_pulse for exactly the one cycle following each wrap cycle.
REQ-017 SHALL hold pps_out high for PULSE_WIDTH cycles starting in the pps_pulse cycle.
REQ-018 SHALL increment sec_count in each pps_pulse cycle, wrapping from 2^32-1 to 0.
REQ-019 SHALL use a registered copy flag_q for edge detection; a request is detected in any cycle where pps_flag!=flag_q. The first cycle after reset SHALL load flag_q without detecting a request (primed bit).
REQ-020 On a request, SHALL capture pps_add into adj_reg and set adj_pending the next cycle.
REQ-021 On a request while adj_pending=1, SHALL overwrite adj_reg (latest wins) and set adj_overwrite.
REQ-022 On capture, if magnitude > MAX_ADJ, SHALL store MAX_ADJ and set adj_clamped.
REQ-023 In a wrap cycle with adj_pending=1, SHALL load per = CLK_FREQ_HZ-mag (shorten) or CLK_FREQ_HZ+mag (lengthen), clear adj_pending, and increment adj_count (wrapping 16 bit).
REQ-024 In a wrap cycle with adj_pending=0, SHALL load per = CLK_FREQ_HZ. An adjustment therefore affects exactly one second.
REQ-025 A request detected in the same cycle as a wrap SHALL NOT apply at that wrap; it SHALL become pending and apply at the next wrap.
REQ-026 A magnitude of 0 SHALL still count as an applied adjustment, with per = CLK_FREQ_HZ.
REQ-027 Period arithmetic SHALL be 32-bit unsigned; clamping guarantees per >= CLK_FREQ_HZ-MAX_ADJ > PULSE_WIDTH.
REQ-028 State machine: RUN (no pending) and PEND (adj_pending). RUN->PEND on request; PEND->PEND on request (overwrite); PEND->RUN on wrap.

Reset
REQ-029 While areset=1, SHALL hold cnt=0, per=CLK_FREQ_HZ, pps_pulse=0, pps_out=0, sec_count=0, adj_pending=0, adj_count=0, adj_overwrite=0, adj_clamped=0, and primed=0.
REQ-030 Reset asserted mid-operation SHALL discard any pending adjustment and truncate pps_out immediately.
REQ-031 After release, the first pps_pulse SHALL occur CLK_FREQ_HZ cycles after the first active edge; the sticky flags SHALL clear only on reset.

Verification (CLK_FREQ_HZ=100, PULSE_WIDTH=10, MAX_ADJ=50)
REQ-032 Free run, no toggles: pps_pulse at cycles 100, 200, 300 after release; pps_out high 10 cycles each; sec_count=3.
REQ-033 pps_add=0x0_0000_0014, toggle at cycle 150: next interval is 120, following interval 100; adj_count=1.
REQ-034 pps_add={1,32'd200}, toggle: adj_clamped=1, one interval of 50, then 100.
REQ-035 Two toggles before a wrap, with values +5 then +7: adj_overwrite=1, a single 107 interval, adj_count=1.
REQ-036 Toggle in the wrap cycle: that interval stays 100; the adjustment applies to the next interval.
REQ-037 areset asserted during PEND and mid-pulse: all outputs are 0 immediately; after release the timing is as in the free-run scenario, with no adjustment applied.

Source files
------------

// File: rtl/internal_pps_gen.sv
// internal_pps_gen: free-running pulse-per-second generator whose period can be
// lengthened or shortened for exactly one second by a toggle-requested adjustment.
module internal_pps_gen #(
    parameter int unsigned CLK_FREQ_HZ = 156250000,
    parameter int unsigned PULSE_WIDTH = 15625,
    parameter int unsigned MAX_ADJ     = 78125000
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [32:0] pps_add,
    input  logic        pps_flag,
    output logic        pps_pulse,
    output logic        pps_out,
    output logic [31:0] sec_count,
    output logic        adj_pending,
    output logic [15:0] adj_count,
    output logic        adj_overwrite,
    output logic        adj_clamped
);
    localparam logic [31:0] C_FREQ = CLK_FREQ_HZ;
    localparam logic [31:0] C_PW   = PULSE_WIDTH;
    localparam logic [31:0] C_MAX  = MAX_ADJ;

    typedef enum logic {S_RUN, S_PEND} t_state;

    t_state      r_state, w_next;
    logic [31:0] r_cnt, r_per, r_wcnt, r_sec, r_adj_mag;
    logic        r_adj_dir, r_flag_q, r_primed, r_pulse, r_out, r_ovw, r_clamp;
    logic [15:0] r_adj_count;
    logic        w_wrap, w_req, w_over;
    logic [31:0] w_mag, w_per_nxt;

    assign w_wrap    = r_cnt == r_per - 32'd1;
    // the first cycle after reset only primes r_flag_q, so a static flag level is not a request
    assign w_req     = r_primed && (pps_flag != r_flag_q);
    assign w_over    = pps_add[31:0] > C_MAX;
    assign w_mag     = w_over ? C_MAX : pps_add[31:0];
    assign w_per_nxt = (r_state == S_PEND) ? (r_adj_dir ? C_FREQ - r_adj_mag : C_FREQ + r_adj_mag) : C_FREQ;

    always_comb begin
        w_next = r_state;
        if (w_req)
            w_next = S_PEND;
        else if (w_wrap)
            w_next = S_RUN;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            r_state <= S_RUN;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_cnt       <= '0;
            r_per       <= C_FREQ;
            r_wcnt      <= '0;
            r_sec       <= '0;
            r_adj_mag   <= '0;
            r_adj_dir   <= 1'b0;
            r_flag_q    <= 1'b0;
            r_primed    <= 1'b0;
            r_pulse     <= 1'b0;
            r_out       <= 1'b0;
            r_ovw       <= 1'b0;
            r_clamp     <= 1'b0;
            r_adj_count <= '0;
        end else begin
            r_flag_q <= pps_flag;
            r_primed <= 1'b1;
            r_cnt    <= w_wrap ? 32'd0 : r_cnt + 32'd1;
            r_pulse  <= w_wrap;
            if (w_wrap) begin
                r_per  <= w_per_nxt;
                r_sec  <= r_sec + 32'd1;
                r_out  <= 1'b1;
                r_wcnt <= C_PW - 32'd1;
                if (r_state == S_PEND)
                    r_adj_count <= r_adj_count + 16'd1;
            end else if (r_wcnt != 32'd0) begin
                r_wcnt <= r_wcnt - 32'd1;
            end else begin
                r_out <= 1'b0;
            end
            if (w_req) begin
                r_adj_dir <= pps_add[32];
                r_adj_mag <= w_mag;
                if (w_over)
                    r_clamp <= 1'b1;
                // a request landing on the wrap follows an applied adjustment, it replaces nothing
                if (r_state == S_PEND && !w_wrap)
                    r_ovw <= 1'b1;
            end
        end
    end

    assign pps_pulse     = r_pulse;
    assign pps_out       = r_out;
    assign sec_count     = r_sec;
    assign adj_pending   = r_state == S_PEND;
    assign adj_count     = r_adj_count;
    assign adj_overwrite = r_ovw;
    assign adj_clamped   = r_clamp;
endmodule

// File: tb/tb_internal_pps_gen.sv
// tb_internal_pps_gen: directed scenarios with hand-computed pulse times for a
// 100-cycle second, 10-cycle pulse and 50-cycle adjustment limit.
module tb_internal_pps_gen;
    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [32:0] pps_add = '0;
    logic        pps_flag = 1'b0;
    logic        pps_pulse, pps_out, adj_pending, adj_overwrite, adj_clamped;
    logic [31:0] sec_count;
    logic [15:0] adj_count;

    int nvec = 0;
    int nerr = 0;
    int cyc;
    int npulse;
    int ptime[0:15];
    int hi_run;
    int last_w;

    internal_pps_gen #(.CLK_FREQ_HZ(100), .PULSE_WIDTH(10), .MAX_ADJ(50)) dut (
        .clk(clk), .areset(areset), .pps_add(pps_add), .pps_flag(pps_flag),
        .pps_pulse(pps_pulse), .pps_out(pps_out), .sec_count(sec_count),
        .adj_pending(adj_pending), .adj_count(adj_count),
        .adj_overwrite(adj_overwrite), .adj_clamped(adj_clamped)
    );

    always #5 clk = ~clk;

    // edges since reset release
    always @(posedge clk or posedge areset)
        if (areset) cyc <= 0;
        else cyc <= cyc + 1;

    always @(negedge clk) begin
        if (areset) begin
            npulse = 0;
            hi_run = 0;
            last_w = 0;
        end else begin
            if (pps_pulse && npulse < 16) begin
                ptime[npulse] = cyc;
                npulse++;
            end
            if (pps_out) hi_run++;
            else if (hi_run != 0) begin
                last_w = hi_run;
                hi_run = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 areset = 1'b1;
        repeat (3) @(negedge clk);
        #2 areset = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int t = 0;
        while (cyc < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic wait_pulses(input int k);
        int t = 0;
        while (npulse < k && t < 2000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("pulse_count", npulse, k);
    endtask

    initial begin
        #1;
        chk("rst_pulse", pps_pulse, 0);
        chk("rst_out", pps_out, 0);
        chk("rst_sec", sec_count, 0);
        chk("rst_pend", adj_pending, 0);
        chk("rst_adjcnt", adj_count, 0);
        chk("rst_ovw", adj_overwrite, 0);
        chk("rst_clamp", adj_clamped, 0);
        repeat (2) @(negedge clk);
        #2 areset = 1'b0;

        // free run
        wait_pulses(3);
        chk("free_p0", ptime[0], 100);
        chk("free_p1", ptime[1], 200);
        chk("free_p2", ptime[2], 300);
        wait_cyc(315);
        chk("free_width", last_w, 10);
        chk("free_sec", sec_count, 3);
        chk("free_adjcnt", adj_count, 0);

        // lengthen by 20 requested mid-second
        do_reset();
        pps_add = 33'h0_0000_0014;
        wait_cyc(150);
        pps_flag = ~pps_flag;
        wait_cyc(153);
        chk("len_pend", adj_pending, 1);
        wait_pulses(4);
        chk("len_p1", ptime[1], 200);
        chk("len_int", ptime[2] - ptime[1], 120);
        chk("len_int_next", ptime[3] - ptime[2], 100);
        chk("len_adjcnt", adj_count, 1);
        chk("len_pend_clr", adj_pending, 0);
        chk("len_clamp", adj_clamped, 0);

        // shorten by 200 clamps to 50
        do_reset();
        pps_add = {1'b1, 32'd200};
        wait_cyc(150);
        pps_flag = ~pps_flag;
        wait_pulses(4);
        chk("clamp_flag", adj_clamped, 1);
        chk("clamp_int", ptime[2] - ptime[1], 50);
        chk("clamp_int_next", ptime[3] - ptime[2], 100);
        chk("clamp_adjcnt", adj_count, 1);

        // two requests before one wrap: latest wins
        do_reset();
        chk("sticky_clr", adj_clamped, 0);
        pps_add = 33'd5;
        wait_cyc(130);
        pps_flag = ~pps_flag;
        wait_cyc(140);
        pps_add = 33'd7;
        pps_flag = ~pps_flag;
        wait_pulses(4);
        chk("ovw_flag", adj_overwrite, 1);
        chk("ovw_int", ptime[2] - ptime[1], 107);
        chk("ovw_int_next", ptime[3] - ptime[2], 100);
        chk("ovw_adjcnt", adj_count, 1);

        // request in the wrap cycle defers by one second
        do_reset();
        chk("ovw_clr", adj_overwrite, 0);
        pps_add = 33'd10;
        wait_cyc(199);
        pps_flag = ~pps_flag;
        wait_pulses(4);
        chk("wrapreq_int1", ptime[2] - ptime[1], 100);
        chk("wrapreq_int2", ptime[3] - ptime[2], 110);
        chk("wrapreq_adjcnt", adj_count, 1);

        // reset while pending and mid-pulse
        do_reset();
        pps_add = 33'd20;
        wait_cyc(201);
        pps_flag = ~pps_flag;
        wait_cyc(205);
        chk("mid_out_pre", pps_out, 1);
        chk("mid_pend_pre", adj_pending, 1);
        #2 areset = 1'b1;
        #1;
        chk("mid_out", pps_out, 0);
        chk("mid_pend", adj_pending, 0);
        chk("mid_sec", sec_count, 0);
        chk("mid_pulse", pps_pulse, 0);
        repeat (2) @(negedge clk);
        #2 areset = 1'b0;
        wait_pulses(3);
        chk("post_p0", ptime[0], 100);
        chk("post_p1", ptime[1], 200);
        chk("post_p2", ptime[2], 300);
        chk("post_adjcnt", adj_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
